// File: rtl/sddt_pkg.sv
// Shared SDDT parameters: default beat width, terminator encoding,
// and the widths of the status counters.
package sddt_pkg;

  localparam int   SDDT_DATA_WIDTH = 512;
  localparam int   SDDT_DROP_W     = 16;
  localparam int   SDDT_PKT_W      = 32;
  localparam logic SDDT_TERM_KEEP  = 1'b0;
  localparam logic SDDT_TERM_LAST  = 1'b1;

endpackage

// File: rtl/sddt_sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Ports: clk, rst, push/din, pop/dout, full, empty, count.
module sddt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is refused even if a pop
  // frees a slot in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rdata_packetizer.sv
// Frames DDR read beats into AXI-Stream packets of pkt_len beats.
// Ports: rd_valid/rd_data/pkt_len/flush in, M_AXIS_RDATA out, status.
module rdata_packetizer
  import sddt_pkg::*;
#(
  parameter int DATA_WIDTH = SDDT_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                      c0_ddr4_clk,
  input  logic                      c0_ddr4_rst,
  input  logic                      rd_valid,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  input  logic [LEN_WIDTH-1:0]      pkt_len,
  input  logic                      flush,
  output logic [DATA_WIDTH-1:0]     M_AXIS_RDATA_tdata,
  output logic [DATA_WIDTH/8-1:0]   M_AXIS_RDATA_tkeep,
  output logic                      M_AXIS_RDATA_tlast,
  output logic                      M_AXIS_RDATA_tvalid,
  input  logic                      M_AXIS_RDATA_tready,
  output logic                      overflow,
  output logic [SDDT_DROP_W-1:0]    drop_count,
  output logic [SDDT_PKT_W-1:0]     pkt_count,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + 2;

  logic [LEN_WIDTH-1:0] wr_cnt;
  logic [LEN_WIDTH-1:0] len_m1;
  logic                 is_last;
  logic                 term;
  logic                 wr_req;
  logic                 push;
  logic                 drop;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [EW-1:0]        din;
  logic [EW-1:0]        dout;

  // pkt_len of 0 behaves as 1, so L-1 saturates at 0.
  assign len_m1  = (pkt_len == '0) ? '0
                 : pkt_len - LEN_WIDTH'(1);
  assign is_last = (wr_cnt >= len_m1) | flush;
  // A lone flush closes an open packet with an empty terminator.
  assign term    = flush & ~rd_valid & (wr_cnt != '0);
  assign wr_req  = rd_valid | term;
  assign push    = wr_req & ~full;
  assign drop    = wr_req & full;

  assign din = rd_valid
             ? {rd_data, 1'b1, is_last}
             : {{DATA_WIDTH{1'b0}}, SDDT_TERM_KEEP, SDDT_TERM_LAST};

  sddt_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (c0_ddr4_clk),
    .rst   (c0_ddr4_rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign M_AXIS_RDATA_tvalid = ~empty;
  assign M_AXIS_RDATA_tdata  = dout[EW-1:2];
  assign M_AXIS_RDATA_tkeep  = {KW{dout[1]}};
  assign M_AXIS_RDATA_tlast  = dout[0];
  assign pop = M_AXIS_RDATA_tvalid & M_AXIS_RDATA_tready;

  // wr_cnt tracks framing even for dropped writes so later
  // packet boundaries stay aligned.
  always_ff @(posedge c0_ddr4_clk or posedge c0_ddr4_rst) begin
    if (c0_ddr4_rst) begin
      wr_cnt     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      pkt_count  <= '0;
    end else begin
      if (rd_valid)
        wr_cnt <= is_last ? '0 : wr_cnt + LEN_WIDTH'(1);
      else if (term)
        wr_cnt <= '0;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1)
          drop_count <= drop_count + 1'b1;
      end
      if (pop && M_AXIS_RDATA_tlast)
        pkt_count <= pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rdata_packetizer.sv
// Directed bench for rdata_packetizer.
// Scoreboards output beats and checks framing and status.
module tb_rdata_packetizer;

  logic        clk;
  logic        rst;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [15:0] pkt_len;
  logic        flush;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        overflow;
  logic [15:0] drop_count;
  logic [31:0] pkt_count;
  logic [4:0]  fifo_count;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t out_q[$];
  int    n_checks;
  int    n_errors;
  logic  prev_stall;
  beat_t prev_b;

  rdata_packetizer #(
    .DATA_WIDTH (32),
    .DEPTH      (16),
    .LEN_WIDTH  (16)
  ) dut (
    .c0_ddr4_clk         (clk),
    .c0_ddr4_rst         (rst),
    .rd_valid            (rd_valid),
    .rd_data             (rd_data),
    .pkt_len             (pkt_len),
    .flush               (flush),
    .M_AXIS_RDATA_tdata  (tdata),
    .M_AXIS_RDATA_tkeep  (tkeep),
    .M_AXIS_RDATA_tlast  (tlast),
    .M_AXIS_RDATA_tvalid (tvalid),
    .M_AXIS_RDATA_tready (tready),
    .overflow            (overflow),
    .drop_count          (drop_count),
    .pkt_count           (pkt_count),
    .fifo_count          (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after posedge; the negedge monitor then
  // sees exactly what the next posedge will act on.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stable", {tdata, tkeep, tlast}, prev_b);
      if (tvalid && tready)
        out_q.push_back({tdata, tkeep, tlast});
      prev_b     = {tdata, tkeep, tlast};
      prev_stall = tvalid && !tready;
    end
  end

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic f);
    @(posedge clk);
    #1;
    rd_valid = v;
    rd_data  = d;
    flush    = f;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] lvec();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < out_q.size() && i < 32; i++)
      r[i] = out_q[i].l;
    return r;
  endfunction

  function automatic logic kall();
    logic r;
    r = 1'b1;
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i].k != 4'hf) r = 1'b0;
    return r;
  endfunction

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    prev_stall = 1'b0;
    rst        = 1'b1;
    rd_valid   = 1'b0;
    rd_data    = '0;
    pkt_len    = 16'd4;
    flush      = 1'b0;
    tready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_tvalid", tvalid, 0);
    check("rst_fifo", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_count, 0);
    check("rst_pkt", pkt_count, 0);

    // two full packets of 4
    tready = 1'b1;
    out_q.delete();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'(i + 1), 1'b0);
    idle(4);
    check("t1_n", out_q.size(), 8);
    check("t1_last", lvec(), 32'h88);
    check("t1_keep", kall(), 1);
    for (int i = 0; i < out_q.size(); i++)
      check("t1_data", out_q[i].d, 64'(i + 1));
    check("t1_pkt", pkt_count, 2);

    // partial packet closed by a lone flush
    out_q.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h11 + 32'(i), 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    idle(4);
    check("t2_n", out_q.size(), 4);
    check("t2_last", lvec(), 32'h8);
    if (out_q.size() == 4) begin
      check("t2_tdata", out_q[3].d, 0);
      check("t2_tkeep", out_q[3].k, 0);
      check("t2_kpre", out_q[2].k, 4'hf);
    end
    check("t2_pkt", pkt_count, 3);

    // flush on the 5th beat; later lone flush is a no-op
    pkt_len = 16'd8;
    out_q.delete();
    for (int i = 0; i < 5; i++)
      drive(1'b1, 32'h31 + 32'(i), (i == 4) ? 1'b1 : 1'b0);
    idle(4);
    drive(1'b0, 32'h0, 1'b1);
    idle(4);
    check("t3_n", out_q.size(), 5);
    check("t3_last", lvec(), 32'h10);
    check("t3_keep", kall(), 1);
    check("t3_pkt", pkt_count, 4);
    check("t3_fifo", fifo_count, 0);

    // overflow with pkt_len=0, then drop against a same-cycle pop
    tready  = 1'b0;
    pkt_len = 16'd0;
    out_q.delete();
    for (int i = 0; i < 20; i++) drive(1'b1, 32'(100 + i), 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    check("t4_fifo", fifo_count, 16);
    check("t4_drop", drop_count, 4);
    check("t4_ovf", overflow, 1);
    drive(1'b1, 32'd200, 1'b0);
    tready = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    tready = 1'b0;
    check("t4_fifo_pop", fifo_count, 15);
    check("t4_drop_pop", drop_count, 5);
    tready = 1'b1;
    idle(20);
    check("t4_n", out_q.size(), 16);
    check("t4_last", lvec(), 32'hffff);
    for (int i = 0; i < out_q.size(); i++)
      check("t4_data", out_q[i].d, 64'(100 + i));
    check("t4_pkt", pkt_count, 20);

    // random backpressure; order and stability
    pkt_len = 16'd3;
    out_q.delete();
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          drive(1'b1, 32'h500 + 32'(i), 1'b0);
          if ($urandom_range(0, 2) == 0) drive(1'b0, 32'h0, 1'b0);
        end
        drive(1'b0, 32'h0, 1'b0);
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          tready = 1'($urandom_range(0, 1));
        end
        tready = 1'b1;
      end
    join
    idle(20);
    check("t5_n", out_q.size(), 12);
    check("t5_last", lvec(), 32'h924);
    for (int i = 0; i < out_q.size(); i++)
      check("t5_data", out_q[i].d, 64'h500 + 64'(i));
    check("t5_pkt", pkt_count, 24);

    // reset mid-packet with 6 beats buffered
    tready  = 1'b0;
    pkt_len = 16'd4;
    for (int i = 0; i < 6; i++) drive(1'b1, 32'h600 + 32'(i), 1'b0);
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("t6_tvalid", tvalid, 0);
    check("t6_fifo", fifo_count, 0);
    check("t6_pkt0", pkt_count, 0);
    check("t6_ovf", overflow, 0);
    check("t6_drop", drop_count, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    tready = 1'b1;
    out_q.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h700 + 32'(i), 1'b0);
    idle(5);
    check("t6_n", out_q.size(), 4);
    check("t6_last", lvec(), 32'h8);
    check("t6_pkt", pkt_count, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rdata_packetizer.md
RDATA_PACKETIZER -- requirements
Module: rdata_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, width of one read-data beat.
REQ-002 SHALL have parameter DEPTH, default 16, buffer entries (power of two, >=4).
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of the packet-length input.
REQ-004 SHALL have port c0_ddr4_clk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port c0_ddr4_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port rd_valid, input, 1, read beat present from the DDR side (no backpressure).
REQ-007 SHALL have port rd_data, input, DATA_WIDTH, read beat payload.
REQ-008 SHALL have port pkt_len, input, LEN_WIDTH, beats per packet; 0 treated as 1.
REQ-009 SHALL have port flush, input, 1, single-cycle pulse that closes the current partial packet.
REQ-010 SHALL have ports M_AXIS_RDATA_tdata (DATA_WIDTH), _tkeep (DATA_WIDTH/8), _tlast (1) and _tvalid (1), all outputs, plus _tready (1), input; together these form an AXI-Stream master toward the DMA.
REQ-011 SHALL have port overflow, output, 1, sticky flag set when a beat or terminator is dropped.
REQ-012 SHALL have port drop_count, output, 16, count of dropped entries, saturating at 0xFFFF.
REQ-013 SHALL have port pkt_count, output, 32, count of packets completed on the output (tlast handshakes), wrapping.
REQ-014 SHALL have port fifo_count, output, $clog2(DEPTH)+1, current buffer occupancy.

Function
REQ-015 Each buffer entry SHALL be {data, keep_bit, last_bit}; tkeep = {DATA_WIDTH/8{keep_bit}}.
REQ-016 The write-side counter wr_cnt SHALL count beats written in the current packet; the effective length is L = (pkt_len==0 ? 1 : pkt_len), sampled each cycle.
REQ-017 A beat with rd_valid=1 and buffer not full SHALL be written with keep_bit=1 and last_bit=(wr_cnt>=L-1 || flush); on last_bit=1, wr_cnt SHALL go to 0, otherwise it SHALL increment.
REQ-018 flush=1 with rd_valid=0 and wr_cnt!=0 SHALL write a terminator entry (data=0, keep_bit=0, last_bit=1) and clear wr_cnt.
REQ-019 flush=1 with rd_valid=0 and wr_cnt==0 SHALL have no effect.
REQ-020 A write attempted while fifo_count==DEPTH SHALL be dropped even if a pop occurs in the same cycle; it SHALL set overflow and increment drop_count. wr_cnt SHALL still advance or clear as if the write had been accepted, so packet boundaries stay aligned.
REQ-021 Latency: an entry written in cycle N SHALL be presentable on M_AXIS_RDATA in cycle N+1 at the earliest.
REQ-022 tvalid SHALL equal (fifo_count!=0); tdata, tkeep and tlast SHALL come from the head entry and be stable while tvalid=1 and tready=0.
REQ-023 A pop SHALL occur on tvalid&&tready; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 pkt_count SHALL increment on every handshake with tlast=1, including terminators.

Reset
REQ-026 Asserting c0_ddr4_rst SHALL immediately clear pointers, fifo_count, wr_cnt, overflow, drop_count and pkt_count, and SHALL drive tvalid low; buffered data is discarded, including on reset mid-packet.
REQ-027 The buffer storage array SHALL NOT be reset.
REQ-028 The first write after reset deassertion SHALL start a new packet (wr_cnt=0).

Structure
REQ-029 DATA_WIDTH default, terminator encoding and the counter widths SHALL live in the shared SDDT parameters header.
REQ-030 Buffering SHALL be one sub-module, sddt_sync_fifo (push, pop, full, empty, count); counters and framing SHALL stay in rdata_packetizer.

Verification
REQ-031 pkt_len=4, 8 consecutive rd_valid beats, tready=1 -> two packets; tlast on output beats 4 and 8; pkt_count=2.
REQ-032 pkt_len=4, 3 beats then flush alone -> 4 output beats; the 4th has tkeep=0, tdata=0, tlast=1; pkt_count=1.
REQ-033 pkt_len=8, 5 beats with flush coincident with beat 5 -> tlast on beat 5 with full tkeep; no terminator.
REQ-034 DEPTH=16, tready=0, 20 beats with pkt_len=0 -> fifo_count=16, drop_count=4, overflow=1, every stored beat tlast=1.
REQ-035 Random tready toggling -> tdata, tkeep and tlast stable while stalled; output order equals input order.
REQ-036 Reset asserted with 6 beats buffered mid-packet -> tvalid=0 and fifo_count=0 in the same cycle; the next 4 beats with pkt_len=4 form one packet.
